ex_stage_pipe: RTL

EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

---
 rtl/ex_stage_pipe_pkg.sv | 35 +++
 rtl/ex_stage_pipe_mul_iter.sv | 80 ++++++++
 rtl/ex_stage_pipe.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pipe_pkg.sv
// Shared types and control-field layout for the execute stage and its iterative multiplier.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
    } alu_op_t;

    typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_t;

    typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

    // ctrl_i = {MemtoReg, MemWrite, MemRead, RegWrite, Branch, ALUSrc, ALUOp[1:0]}
    localparam int CTRL_MEMTOREG = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    // MEM wins over WB; x0 is never forwarded.
    function automatic fwd_sel_t fwd_select(input logic       mem_en,
                                            input logic [4:0] mem_rd,
                                            input logic       wb_en,
                                            input logic [4:0] wb_rd,
                                            input logic [4:0] rs);
        if (rs == 5'd0)                    return FWD_REG;
        else if (mem_en && mem_rd == rs)   return FWD_MEM;
        else if (wb_en && wb_rd == rs)     return FWD_WB;
        else                               return FWD_REG;
    endfunction

endpackage

// File: rtl/ex_stage_pipe_mul_iter.sv
// Iterative shift-add multiplier returning the low XLEN bits; retires ceil(XLEN/STEPS)
// multiplier bits per BUSY cycle. state_o exposes the FSM for the parent and for checkers.
module mul_iter
    import ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEPS = XLEN
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output mul_state_t      state_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int BITS = (XLEN + STEPS - 1) / STEPS;
    localparam int CW   = $clog2(STEPS + 1);

    mul_state_t      state_q, state_d;
    logic [XLEN-1:0] acc_q, a_q, b_q, step_acc;
    logic [CW-1:0]   count_q;

    always_comb begin
        step_acc = acc_q;
        for (int k = 0; k < BITS; k++) begin
            if (b_q[k]) step_acc = step_acc + (a_q << k);
        end
    end

    always_comb begin
        state_d = state_q;
        done_o  = 1'b0;
        case (state_q)
            MUL_IDLE: if (start_i) state_d = MUL_BUSY;
            MUL_BUSY: if (count_q == CW'(STEPS - 1)) state_d = MUL_DONE;
            MUL_DONE: if (!stall_i) begin
                done_o  = 1'b1;
                state_d = MUL_IDLE;
            end
            default:  state_d = MUL_IDLE;
        endcase
        if (flush_i) begin
            done_o  = 1'b0;
            state_d = MUL_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= MUL_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            count_q <= '0;
        end else if (state_q == MUL_IDLE && start_i && !flush_i) begin
            acc_q   <= '0;
            a_q     <= a_i;
            b_q     <= b_i;
            count_q <= '0;
        end else if (state_q == MUL_BUSY) begin
            acc_q   <= step_acc;
            a_q     <= a_q << BITS;
            b_q     <= b_q >> BITS;
            count_q <= count_q + CW'(1);
        end
    end

    assign state_o  = state_q;
    assign result_o = acc_q;

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage: operand forwarding, ALU, branch resolution and an optional iterative
// multiplier feeding a single output register.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit ENABLE_MUL = 1'b1,
    parameter int MUL_STEPS  = XLEN
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [7:0]      ctrl_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            fwd_mem_en_i,
    input  logic [4:0]      fwd_mem_rd_i,
    input  logic [XLEN-1:0] fwd_mem_data_i,
    input  logic            fwd_wb_en_i,
    input  logic [4:0]      fwd_wb_rd_i,
    input  logic [XLEN-1:0] fwd_wb_data_i,
    output logic            valid_o,
    output logic [4:0]      ctrl_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [XLEN-1:0] branch_target_o,
    output logic            zero_o,
    output logic            branch_taken_o,
    output logic [4:0]      rd_o
);

    localparam int SHW = $clog2(XLEN);

    fwd_sel_t        sel1, sel2;
    alu_op_t         alu_op;
    mul_state_t      mul_state;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd, op2, alu_res, mul_result;
    logic [SHW-1:0]  shamt;
    logic            br_cond, accept, is_mul, mul_done;
    logic [4:0]      hold_ctrl, hold_rd;
    logic [XLEN-1:0] hold_store, hold_target;

    assign sel1 = fwd_select(fwd_mem_en_i, fwd_mem_rd_i, fwd_wb_en_i, fwd_wb_rd_i, rs1_i);
    assign sel2 = fwd_select(fwd_mem_en_i, fwd_mem_rd_i, fwd_wb_en_i, fwd_wb_rd_i, rs2_i);

    always_comb begin
        case (sel1)
            FWD_MEM: rs1_fwd = fwd_mem_data_i;
            FWD_WB:  rs1_fwd = fwd_wb_data_i;
            default: rs1_fwd = rs1_data_i;
        endcase
        case (sel2)
            FWD_MEM: rs2_fwd = fwd_mem_data_i;
            FWD_WB:  rs2_fwd = fwd_wb_data_i;
            default: rs2_fwd = rs2_data_i;
        endcase
    end

    assign op2   = ctrl_i[CTRL_ALUSRC] ? imm_i : rs2_fwd;
    assign shamt = op2[SHW-1:0];

    always_comb begin
        alu_op = ALU_ADD;
        case (ctrl_i[CTRL_ALUOP_HI:CTRL_ALUOP_LO])
            2'b01: alu_op = ALU_SUB;
            2'b10: begin
                case (funct3_i)
                    3'b000: alu_op = (funct7_i == 7'b0000001) ? ALU_MUL :
                                     (funct7_i[5] ? ALU_SUB : ALU_ADD);
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = funct7_i[5] ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
        if (!ENABLE_MUL && alu_op == ALU_MUL) alu_op = ALU_ADD;
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = rs1_fwd + op2;
            ALU_SUB:  alu_res = rs1_fwd - op2;
            ALU_SLL:  alu_res = rs1_fwd << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_fwd) < $signed(op2)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1_fwd < op2};
            ALU_XOR:  alu_res = rs1_fwd ^ op2;
            ALU_SRL:  alu_res = rs1_fwd >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(rs1_fwd) >>> shamt);
            ALU_OR:   alu_res = rs1_fwd | op2;
            ALU_AND:  alu_res = rs1_fwd & op2;
            default:  alu_res = '0;
        endcase
    end

    // Branches compare the forwarded registers, not the ALU operands.
    always_comb begin
        case (funct3_i)
            3'b000:  br_cond = (rs1_fwd == rs2_fwd);
            3'b001:  br_cond = (rs1_fwd != rs2_fwd);
            3'b100:  br_cond = ($signed(rs1_fwd) <  $signed(rs2_fwd));
            3'b101:  br_cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
            3'b110:  br_cond = (rs1_fwd <  rs2_fwd);
            3'b111:  br_cond = (rs1_fwd >= rs2_fwd);
            default: br_cond = 1'b0;
        endcase
    end

    assign ready_o = (mul_state == MUL_IDLE) && !stall_i && !reset_i;
    assign accept  = valid_i && ready_o && !flush_i;
    assign is_mul  = (alu_op == ALU_MUL);

    if (ENABLE_MUL) begin : g_mul
        mul_iter #(.XLEN(XLEN), .STEPS(MUL_STEPS)) u_mul (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .flush_i  (flush_i),
            .stall_i  (stall_i),
            .start_i  (accept && is_mul),
            .a_i      (rs1_fwd),
            .b_i      (op2),
            .state_o  (mul_state),
            .done_o   (mul_done),
            .result_o (mul_result)
        );
    end else begin : g_no_mul
        assign mul_state  = MUL_IDLE;
        assign mul_done   = 1'b0;
        assign mul_result = '0;
    end

    // Side-band fields of a multiply wait here until the product is ready.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_ctrl   <= '0;
            hold_rd     <= '0;
            hold_store  <= '0;
            hold_target <= '0;
        end else if (accept && is_mul) begin
            hold_ctrl   <= ctrl_i[CTRL_MEMTOREG:CTRL_BRANCH];
            hold_rd     <= rd_i;
            hold_store  <= rs2_fwd;
            hold_target <= pc_i + imm_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o         <= 1'b0;
            ctrl_o          <= '0;
            alu_result_o    <= '0;
            store_data_o    <= '0;
            branch_target_o <= '0;
            zero_o          <= 1'b0;
            branch_taken_o  <= 1'b0;
            rd_o            <= '0;
        end else if (flush_i) begin
            valid_o        <= 1'b0;
            ctrl_o         <= '0;
            branch_taken_o <= 1'b0;
        end else if (!stall_i) begin
            if (mul_done) begin
                valid_o         <= 1'b1;
                ctrl_o          <= hold_ctrl;
                alu_result_o    <= mul_result;
                store_data_o    <= hold_store;
                branch_target_o <= hold_target;
                zero_o          <= (mul_result == '0);
                branch_taken_o  <= 1'b0;
                rd_o            <= hold_rd;
            end else if (accept && !is_mul) begin
                valid_o         <= 1'b1;
                ctrl_o          <= ctrl_i[CTRL_MEMTOREG:CTRL_BRANCH];
                alu_result_o    <= alu_res;
                store_data_o    <= rs2_fwd;
                branch_target_o <= pc_i + imm_i;
                zero_o          <= (alu_res == '0);
                branch_taken_o  <= ctrl_i[CTRL_BRANCH] && br_cond;
                rd_o            <= rd_i;
            end else begin
                valid_o        <= 1'b0;
                ctrl_o         <= '0;
                branch_taken_o <= 1'b0;
            end
        end
    end

endmodule
